text_buffer: RTL and testbench
==============================

# text_buffer

Character-entry stage feeding the VGA controller's 11-entry ASCII array. Accepts a byte stream over a valid/ready handshake and edits a private working line: printable write at the cursor, backspace, clear. On an enter code it commits the working line to the displayed array, but only at the next vertical-sync falling edge, so the array never changes during active video.

## Interface
Parameters:
- N_CHARS, 11: displayed characters; must match the VGA controller's array depth.
- BLANK, 8'd0: fill code for empty positions.

Ports:
- clock_25  input  1  pixel clock; all state is on its rising edge.
- reset  input  1  asynchronous, active-low.
- in_valid  input  1  in_data is offered.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  8  ASCII character or control code.
- vsync  input  1  active-low vertical sync level from the sync generator, same clock domain.
- char  output  N_CHARS x 8  committed line, index 0 leftmost; connects to the VGA controller's char input.
- cursor  output  4  next write position, 0..N_CHARS.
- full  output  1  cursor == N_CHARS.
- overflow  output  1  sticky: a printable was dropped while full.
- pending  output  1  commit requested, waiting for frame edge.

## Operation
- Transfer occurs on the edge where in_valid && in_ready.
- Codes:
  - 0x20..0x7E printable: if not full, work[cursor] <= code, cursor+1. If full, drop it and set overflow.
  - 0x08 backspace: if cursor > 0, cursor-1 and work[cursor-1] <= BLANK. At cursor 0, no effect.
  - 0x0C clear: all work <= BLANK, cursor <= 0, overflow <= 0. char is unaffected.
  - 0x0D enter: request a commit.
  - Any other code: accepted and discarded.
- FSM has two states:
  - EDIT: in_ready=1. An accepted 0x0D moves to PENDING.
  - PENDING: in_ready=0, pending=1. On frame_edge: char <= work, overflow <= 0, go to EDIT. The working line and cursor are kept, so editing continues from the same text.
- frame_edge = vsync_q && !vsync. vsync_q is vsync registered, with reset value 1.
- frame_edge while in EDIT is ignored.
- Reset is asynchronous with immediate effect:
  - work and char all BLANK; cursor 0.
  - overflow 0, pending 0, state EDIT, in_ready 1, vsync_q 1.
- Reset asserted while PENDING: the commit is abandoned.

## Timing
- An edit is visible on cursor, full and overflow the cycle after acceptance. char is unchanged by edits.
- 0x0D accepted at edge T: pending=1 and in_ready=0 from T.
- Commit happens at the first edge F > T where frame_edge=1. char updates at F; in_ready returns to 1 after F.
- A frame_edge at T itself, or before T, does not commit.
- Worst-case commit latency is one frame (420,000 cycles at 640x480@60). Upstream must hold in_valid/in_data stable while in_ready=0.
- char changes only at vsync falling edges, and is stable for whole frames.

## Structure
- Package text_pkg holds:
  - N_CHARS and BLANK defaults.
  - Constants CODE_BS=8'h08, CODE_CLR=8'h0C, CODE_ENTER=8'h0D, PRINT_LO=8'h20, PRINT_HI=8'h7E.
  - Enum state_t {EDIT, PENDING}.
- One sub-module, vsync_edge: a registered vsync_q and a combinational one-cycle frame_edge, with reset behaviour as above.
- The core is the working array, cursor/overflow registers, the FSM, and the commit copy.

## Test plan
- Reset, then feed "0","1","2" (0x30,0x31,0x32) and 0x0D, then a vsync 1→0 transition. Required: char = {0x30,0x31,0x32, then 8 x 0x00}; cursor=3; in_ready low from the 0x0D edge until the vsync edge.
- Feed 12 printables with vsync held high. Required: cursor=11, full=1, overflow=1, the 12th byte absent from work, char still all 0x00.
- Sequence "A","B", 0x08, 0x08, 0x08, "C", commit. Required: char[0]=0x43 and the remaining 10 entries 0x00; cursor=1; the third backspace has no effect.
- 0x0D accepted in the same cycle as a vsync falling edge. Required: no commit at that edge; commit occurs at the following vsync falling edge.
- While PENDING: hold in_valid=1 with 0x41. Required: not accepted until after commit, then written at the next cursor position. Separately, assert reset mid-PENDING. Required: char all 0x00, pending=0, in_ready=1 immediately.

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants and types for the character-entry stage that feeds the VGA text array.
package text_pkg;

    localparam int         N_CHARS_DEFAULT = 11;
    localparam logic [7:0] BLANK_DEFAULT   = 8'h00;

    localparam logic [7:0] CODE_BS    = 8'h08;
    localparam logic [7:0] CODE_CLR   = 8'h0C;
    localparam logic [7:0] CODE_ENTER = 8'h0D;
    localparam logic [7:0] PRINT_LO   = 8'h20;
    localparam logic [7:0] PRINT_HI   = 8'h7E;

    typedef enum logic {
        EDIT,
        PENDING
    } state_t;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= PRINT_LO) && (code <= PRINT_HI);
    endfunction

endpackage

// File: rtl/text_buffer_vsync_edge.sv
// Detects the falling edge of the active-low vsync level; frame_edge is high for one cycle.
module vsync_edge (
    input  logic clock_25,
    input  logic reset,
    input  logic vsync,
    output logic frame_edge
);

    logic vsync_q;

    // Resets high so a low vsync level at reset release does not look like an edge.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            vsync_q <= 1'b1;
        end else begin
            vsync_q <= vsync;
        end
    end

    assign frame_edge = vsync_q && !vsync;

endmodule

// File: rtl/text_buffer.sv
// Working-line editor: printable/backspace/clear edits a private line, enter commits it to the
// displayed array at the next vsync falling edge so the array never changes mid-frame.
module text_buffer
    import text_pkg::*;
#(
    parameter int         N_CHARS = N_CHARS_DEFAULT,
    parameter logic [7:0] BLANK   = BLANK_DEFAULT
) (
    input  logic                    clock_25,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    input  logic                    vsync,
    output logic [N_CHARS-1:0][7:0] char,
    output logic [3:0]              cursor,
    output logic                    full,
    output logic                    overflow,
    output logic                    pending
);

    state_t                    state_q;
    state_t                    state_d;
    logic [N_CHARS-1:0][7:0]   work;
    logic                      frame_edge;
    logic                      accept;
    logic                      commit;

    vsync_edge u_vsync_edge (
        .clock_25   (clock_25),
        .reset      (reset),
        .vsync      (vsync),
        .frame_edge (frame_edge)
    );

    assign accept = in_valid && in_ready;
    assign full   = (cursor == 4'(N_CHARS));

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q <= EDIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        pending  = 1'b0;
        commit   = 1'b0;
        case (state_q)
            EDIT: begin
                in_ready = 1'b1;
                if (in_valid && (in_data == CODE_ENTER)) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                pending = 1'b1;
                if (frame_edge) begin
                    commit  = 1'b1;
                    state_d = EDIT;
                end
            end
            default: state_d = EDIT;
        endcase
    end

    // Commit and accept are mutually exclusive because input is stalled while pending.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            work     <= {N_CHARS{BLANK}};
            char     <= {N_CHARS{BLANK}};
            cursor   <= 4'd0;
            overflow <= 1'b0;
        end else if (commit) begin
            char     <= work;
            overflow <= 1'b0;
        end else if (accept) begin
            if (is_printable(in_data)) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    for (int i = 0; i < N_CHARS; i++) begin
                        if (4'(i) == cursor) begin
                            work[i] <= in_data;
                        end
                    end
                    cursor <= cursor + 4'd1;
                end
            end else if (in_data == CODE_BS) begin
                if (cursor != 4'd0) begin
                    for (int i = 0; i < N_CHARS; i++) begin
                        if (4'(i) == (cursor - 4'd1)) begin
                            work[i] <= BLANK;
                        end
                    end
                    cursor <= cursor - 4'd1;
                end
            end else if (in_data == CODE_CLR) begin
                work     <= {N_CHARS{BLANK}};
                cursor   <= 4'd0;
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_text_buffer.sv
// Directed self-checking bench for text_buffer with hand-computed expected lines.
module tb_text_buffer;

    logic             clock_25;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             vsync;
    logic [10:0][7:0] char;
    logic [3:0]       cursor;
    logic             full;
    logic             overflow;
    logic             pending;

    int total = 0;
    int bad   = 0;

    logic [10:0][7:0] expLine;

    text_buffer dut (
        .clock_25 (clock_25),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .vsync    (vsync),
        .char     (char),
        .cursor   (cursor),
        .full     (full),
        .overflow (overflow),
        .pending  (pending)
    );

    initial clock_25 = 1'b0;
    always #20 clock_25 = ~clock_25;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock_25);
        #1;
    endtask

    // Offers one byte and waits (bounded) for it to be accepted.
    task automatic applyStimulus(input logic [7:0] code);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = code;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) checkOutput("accept_timeout", 0, 1);
    endtask

    // One vsync falling edge; the edge seen at the next clock commits a pending line.
    task automatic vsyncFall();
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
    endtask

    task automatic doReset();
        @(negedge clock_25);
        reset = 1'b0;
        #5;
        @(negedge clock_25);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        vsync    = 1'b1;
        #7;
        reset = 1'b0;
        #3;
        checkOutput("rst_char", char, 0);
        checkOutput("rst_cursor", cursor, 0);
        checkOutput("rst_pending", pending, 0);
        checkOutput("rst_ready", in_ready, 1);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_full", full, 0);
        @(negedge clock_25);
        reset = 1'b1;
        tick();

        // "012" then enter, committed on the next vsync fall
        applyStimulus(8'h30);
        applyStimulus(8'h31);
        applyStimulus(8'h32);
        checkOutput("t1_cursor_pre", cursor, 3);
        checkOutput("t1_char_pre", char, 0);
        applyStimulus(8'h0D);
        checkOutput("t1_pending", pending, 1);
        checkOutput("t1_ready_low", in_ready, 0);
        tick();
        tick();
        checkOutput("t1_still_pending", pending, 1);
        checkOutput("t1_char_wait", char, 0);
        vsync = 1'b0;
        tick();
        expLine    = '0;
        expLine[0] = 8'h30;
        expLine[1] = 8'h31;
        expLine[2] = 8'h32;
        checkOutput("t1_char", char, expLine);
        checkOutput("t1_cursor", cursor, 3);
        checkOutput("t1_ready_back", in_ready, 1);
        checkOutput("t1_pending_clr", pending, 0);
        vsync = 1'b1;
        tick();

        // 12 printables: 11 fit, 12th dropped and flags overflow
        doReset();
        for (int i = 0; i < 12; i++) applyStimulus(8'h61 + 8'(i));
        checkOutput("t2_cursor", cursor, 11);
        checkOutput("t2_full", full, 1);
        checkOutput("t2_overflow", overflow, 1);
        checkOutput("t2_char", char, 0);
        applyStimulus(8'h0D);
        vsyncFall();
        for (int i = 0; i < 11; i++) expLine[i] = 8'h61 + 8'(i);
        checkOutput("t2_commit", char, expLine);
        checkOutput("t2_ovf_clr", overflow, 0);

        // clear empties the working line but leaves char alone
        applyStimulus(8'h0C);
        checkOutput("clr_cursor", cursor, 0);
        checkOutput("clr_char_kept", char, expLine);

        // backspace sequence, third backspace at cursor 0 has no effect
        doReset();
        applyStimulus(8'h41);
        applyStimulus(8'h42);
        applyStimulus(8'h08);
        applyStimulus(8'h08);
        checkOutput("t3_cursor_bs2", cursor, 0);
        applyStimulus(8'h08);
        checkOutput("t3_cursor_bs3", cursor, 0);
        applyStimulus(8'h43);
        applyStimulus(8'h0D);
        vsyncFall();
        expLine    = '0;
        expLine[0] = 8'h43;
        checkOutput("t3_char", char, expLine);
        checkOutput("t3_cursor", cursor, 1);

        // enter accepted on the same edge as a vsync fall does not commit there
        doReset();
        applyStimulus(8'h58);
        vsync = 1'b0;
        applyStimulus(8'h0D);
        checkOutput("t4_pending", pending, 1);
        checkOutput("t4_no_commit", char, 0);
        tick();
        tick();
        checkOutput("t4_low_hold", char, 0);
        vsync = 1'b1;
        tick();
        vsyncFall();
        expLine    = '0;
        expLine[0] = 8'h58;
        checkOutput("t4_commit", char, expLine);
        checkOutput("t4_pending_clr", pending, 0);

        // byte held during PENDING waits until after commit
        applyStimulus(8'h0D);
        in_valid = 1'b1;
        in_data  = 8'h41;
        tick();
        tick();
        tick();
        checkOutput("t5_cursor_stall", cursor, 1);
        checkOutput("t5_ready_low", in_ready, 0);
        vsync = 1'b0;
        tick();
        checkOutput("t5_commit_noA", char, expLine);
        checkOutput("t5_cursor_at_F", cursor, 1);
        checkOutput("t5_ready_after_F", in_ready, 1);
        tick();
        in_valid = 1'b0;
        vsync    = 1'b1;
        checkOutput("t5_cursor_A", cursor, 2);
        tick();
        applyStimulus(8'h0D);
        vsyncFall();
        expLine[1] = 8'h41;
        checkOutput("t5_char_A", char, expLine);

        // reset in the middle of PENDING abandons the commit at once
        applyStimulus(8'h0D);
        checkOutput("t6_pending", pending, 1);
        #5;
        reset = 1'b0;
        #1;
        checkOutput("t6_char", char, 0);
        checkOutput("t6_pending", pending, 0);
        checkOutput("t6_ready", in_ready, 1);
        checkOutput("t6_cursor", cursor, 0);
        @(negedge clock_25);
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
